// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-adder arbiter.
package adder_arbiter_pkg;
  localparam int ADDER_W = 32;
  localparam int MAX_REQ = 8;
  localparam int MAX_IDW = 3;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDW-1:0]   idx;
  } rr_pick_t;

  function automatic logic [MAX_IDW-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | MAX_IDW'(i);
    return idx;
  endfunction

  // Searches from last+1 upward, wrapping at n; first valid bit wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [MAX_IDW-1:0] last,
                                       input int n);
    rr_pick_t r;
    int j;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j = (int'(last) + k) % n;
      if (k <= n && !r.found && valid[j]) begin
        r.found = 1'b1;
        r.idx   = MAX_IDW'(j);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between requesters, consumer and the shared-adder arbiter.
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0][ADDER_W-1:0] req_a;
  logic [NREQ-1:0][ADDER_W-1:0] req_b;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ADDER_W-1:0]           rsp_data;
  logic [IDW-1:0]               rsp_id;
  logic                         rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );
endinterface

// File: rtl/Adder.sv
// Shared 32-bit combinational adder; carry out is not exported.
module Adder
  import adder_arbiter_pkg::*;
(
  input  logic [ADDER_W-1:0] a,
  input  logic [ADDER_W-1:0] b,
  output logic [ADDER_W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/adder_arbiter_rr_arbiter_core.sv
// Combinational round-robin pick: winner is the first valid requester after last.
module rr_arbiter_core
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
)(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  winner,
  output logic            found
);
  rr_pick_t pick;
  logic     unused_idx;

  assign pick       = rr_pick(MAX_REQ'(req), MAX_IDW'(last), NREQ);
  assign winner     = IDW'(pick.idx);
  assign found      = pick.found;
  assign unused_idx = ^pick.idx;
endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NREQ requesters; result lands in a single held output slot.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
)(
  input  logic            clk,
  input  logic            reset,
  adder_arbiter_if.slave  bus,
  output logic [CNTW-1:0] op_count
);
  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  logic [0:0]         slot;
  logic [IDW-1:0]     rr_last, winner, id_q;
  logic               found, can_accept, accept, ovf_q;
  logic [ADDER_W-1:0] op_a, op_b, sum, data_q;

  assign bus.rsp_valid = (slot == SLOT_FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_ovf   = ovf_q;

  // A full slot can only take a new result when it is being drained this cycle.
  assign can_accept = !bus.rsp_valid || bus.rsp_ready;
  assign accept     = found && can_accept;

  rr_arbiter_core #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (bus.req_valid),
    .last   (rr_last),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[winner] = 1'b1;
  end

  assign op_a = bus.req_a[winner];
  assign op_b = bus.req_b[winner];

  Adder u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      slot     <= SLOT_EMPTY;
      data_q   <= '0;
      id_q     <= '0;
      ovf_q    <= 1'b0;
      op_count <= '0;
      rr_last  <= IDW'(NREQ - 1);
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) op_count <= op_count + CNTW'(1);
      if (accept) begin
        slot    <= SLOT_FULL;
        data_q  <= sum;
        id_q    <= winner;
        ovf_q   <= (op_a[ADDER_W-1] == op_b[ADDER_W-1]) && (sum[ADDER_W-1] != op_a[ADDER_W-1]);
        rr_last <= winner;
      end else if (bus.rsp_ready) begin
        slot    <= SLOT_EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with hand-computed expectations (CNTW=4 to reach counter wrap).
module tb_adder_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [CNTW-1:0] op_count;
  int              n_chk = 0;
  int              n_fail = 0;

  adder_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    do_reset();

    // reset state
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_data",  bus.rsp_data,       32'd0);
    chk("rst_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_ovf",   32'(bus.rsp_ovf),   32'd0);
    chk("rst_cnt",   32'(op_count),      32'd0);

    // idle: nothing changes
    tick();
    chk("idle_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_cnt",   32'(op_count),      32'd0);

    // single request 5+7
    bus.req_valid = 4'b0001;
    bus.req_a[0] = 32'd5;
    bus.req_b[0] = 32'd7;
    settle();
    chk("first_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("first_valid", 32'(bus.rsp_valid), 32'd1);
    chk("first_data",  bus.rsp_data,       32'd12);
    chk("first_id",    32'(bus.rsp_id),    32'd0);
    chk("first_ovf",   32'(bus.rsp_ovf),   32'd0);
    bus.req_valid = '0;
    tick();
    chk("first_drain_valid", 32'(bus.rsp_valid), 32'd0);
    chk("first_drain_cnt",   32'(op_count),      32'd1);

    // round robin with all four valid
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i] = 32'h100 * (i + 1);
      bus.req_b[i] = 32'(i);
    end
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("rr_ready%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      tick();
      chk($sformatf("rr_id%0d", k),   32'(bus.rsp_id), 32'(k % 4));
      chk($sformatf("rr_data%0d", k), bus.rsp_data,    32'h100 * ((k % 4) + 1) + 32'(k % 4));
    end
    bus.req_valid = '0;
    tick();
    chk("rr_cnt", 32'(op_count), 32'd8);

    // overflow boundaries, back-to-back on requester 0 (rr_last=3)
    bus.req_valid = 4'b0001;
    bus.req_a[0] = 32'h7FFF_FFFF; bus.req_b[0] = 32'd1;
    tick();
    chk("ovf_pos_data", bus.rsp_data,     32'h8000_0000);
    chk("ovf_pos_flag", 32'(bus.rsp_ovf), 32'd1);
    bus.req_a[0] = 32'hFFFF_FFFF; bus.req_b[0] = 32'd1;
    tick();
    chk("carry_data", bus.rsp_data,     32'd0);
    chk("carry_flag", 32'(bus.rsp_ovf), 32'd0);
    bus.req_a[0] = 32'h8000_0000; bus.req_b[0] = 32'h8000_0000;
    tick();
    chk("ovf_neg_data", bus.rsp_data,     32'd0);
    chk("ovf_neg_flag", 32'(bus.rsp_ovf), 32'd1);
    bus.req_valid = '0;
    tick();
    chk("ovf_cnt", 32'(op_count), 32'd11);

    // backpressure on requester 2
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_a[2] = 32'd100; bus.req_b[2] = 32'd23;
    tick();
    chk("bp_load_data", bus.rsp_data,    32'd123);
    chk("bp_load_id",   32'(bus.rsp_id), 32'd2);
    bus.req_a[2] = 32'd200; bus.req_b[2] = 32'd1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("bp_ready%0d", k), 32'(bus.req_ready), 32'd0);
      tick();
      chk($sformatf("bp_valid%0d", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d", k),  bus.rsp_data,       32'd123);
    end
    bus.rsp_ready = 1'b1;
    settle();
    chk("bp_release_ready", 32'(bus.req_ready), 32'h4);
    tick();
    chk("bp_b2b_data",  bus.rsp_data,       32'd201);
    chk("bp_b2b_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_b2b_cnt",   32'(op_count),      32'd12);
    bus.req_valid = '0;
    tick();
    chk("bp_empty", 32'(bus.rsp_valid), 32'd0);
    chk("bp_cnt",   32'(op_count),      32'd13);

    // reset with a pending result
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_a[0] = 32'd1; bus.req_b[0] = 32'd1;
    tick();
    chk("mid_pending", 32'(bus.rsp_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_cnt",   32'(op_count),      32'd0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1001;
    bus.req_a[3] = 32'd30; bus.req_b[3] = 32'd3;
    settle();
    chk("mid_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("mid_id",   32'(bus.rsp_id), 32'd0);
    chk("mid_data", bus.rsp_data,    32'd2);

    // single continuous requester, counter wrap at CNTW=4
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_a[1] = 32'd9; bus.req_b[1] = 32'd1;
    for (int k = 0; k < 17; k++) begin
      settle();
      chk($sformatf("solo_ready%0d", k), 32'(bus.req_ready), 32'h2);
      tick();
    end
    bus.req_valid = '0;
    tick();
    chk("wrap_cnt", 32'(op_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit combinational adder between NREQ requesters, e.g. PC+4, branch-target and address-calc units.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Result is registered into a single output slot that holds under backpressure.
- Sits between the fetch/execute units and the shared `Adder` instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must satisfy 2**IDW >= NREQ.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  32*NREQ  packed operand A; requester i uses bits [32*i+31:32*i].
- req_b  in  32*NREQ  packed operand B, same packing.
- req_ready  out  NREQ  one-hot accept; the transfer happens when req_valid[i] & req_ready[i].
- rsp_valid  out  1  result slot full.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  sum A+B, modulo 2^32.
- rsp_id  out  IDW  index of the requester that produced the result.
- rsp_ovf  out  1  signed overflow of the sum.
- op_count  out  CNTW  number of results consumed; wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, op_count=0, rr_last=NREQ-1. After reset, requester 0 has top priority.
- can_accept = !rsp_valid | rsp_ready.
- Arbitration (combinational): search req_valid starting at index rr_last+1, wrapping modulo NREQ. The first set bit is the winner.
- req_ready: one-hot at the winner when can_accept; all zeros otherwise.
- req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- On accept at edge k:
  - rsp_data <= A+B, from the shared adder fed by a mux on the winner.
  - rsp_id <= winner.
  - rsp_ovf <= (A[31]==B[31]) & (sum[31]!=A[31]).
  - rsp_valid <= 1.
  - rr_last <= winner.
- Latency: exactly 1 cycle from accept to rsp_valid.
- Throughput: 1 op per cycle while rsp_ready=1.
- Output slot states:
  - EMPTY (rsp_valid=0): go to FULL on accept.
  - FULL, not consumed: hold rsp_data, rsp_id and rsp_ovf stable. No grant; req_ready=0.
  - FULL, rsp_ready=1 with a new accept in the same cycle: load the new result and stay FULL (back-to-back).
  - FULL, rsp_ready=1 with no request: go to EMPTY. rsp_data is retained; it is don't-care.
- op_count increments on every rsp_valid & rsp_ready and wraps from 2^CNTW-1 to 0.
- No requests: rr_last is unchanged and no state changes.
- A single requester that is continuously valid gets every slot.
- Round-robin fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,...
- Carry out of bit 31 is discarded. rsp_ovf reports signed overflow only.
- Reset mid-operation: any pending result is dropped and rsp_valid=0 next cycle. Requesters must re-present their operands.
- Operand stability: operands are sampled only on the accept edge. A requester may change them freely while not accepted.

Decomposition:
- Shared package holds:
  - ADDER_W = 32.
  - A function onehot_to_idx.
  - A function rr_pick(valid, last) returning the winner index plus a found flag.
- One sub-module: rr_arbiter_core (NREQ, IDW). Inputs: req mask, rr_last. Outputs: winner, found. Pure combinational.
- The existing `Adder` is instantiated once inside adder_arbiter, with its operands fed by the winner mux.

Test Plan:
- Reset, then req_valid=0001, A0=5, B0=7 -> req_ready=0001 on the same cycle; next cycle rsp_valid=1, rsp_data=12, rsp_id=0, rsp_ovf=0.
- All four requesters valid, rsp_ready=1, for 8 cycles -> grants 0,1,2,3,0,1,2,3 and op_count=8.
- A=32'h7FFFFFFF, B=1 -> rsp_data=32'h80000000, rsp_ovf=1.
- A=32'hFFFFFFFF, B=1 -> rsp_data=0, rsp_ovf=0.
- Hold rsp_ready=0 for 3 cycles with requester 2 valid -> req_ready=0 and rsp_data stable throughout. Release -> requester 2 is accepted on the release cycle (back-to-back).
- Assert reset while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0 and op_count=0. The next grant goes to requester 0 when requesters 0 and 3 are both valid.
- Preset op_count near wrap (CNTW=4), complete 17 ops -> op_count=1.
